loba_seq_mult_ctrl: RTL

- Sequential controller for a LOBA-style approximate multiplier that shares one K×K multiplier and one shifter-accumulator.
- Splits each operand into a high segment at its leading one and a low segment at the leading one of the remainder.
- Issues up to four partial products, one per cycle: HH, HL, LH, LL.
- Accuracy level is chosen per transaction. Sits between a valid/ready producer and consumer in MAxPy approximate-arithmetic datapaths.

---
 rtl/loba_seq_mult_ctrl_if.sv | 25 ++
 rtl/loba_seq_mult_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/loba_seq_mult_ctrl_if.sv
// Handshake bundle for the LOBA sequential multiplier controller.
// The producer/consumer side uses the master modport; the controller uses slave.
interface loba_seq_mult_ctrl_if #(
    parameter int NA = 16,
    parameter int NB = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [NA-1:0]      in_a;
    logic [NB-1:0]      in_b;
    logic [1:0]         in_terms;
    logic               out_valid;
    logic               out_ready;
    logic [NA+NB-1:0]   out_r;

    modport master (
        output in_valid, in_a, in_b, in_terms, out_ready,
        input  in_ready, out_valid, out_r
    );

    modport slave (
        input  in_valid, in_a, in_b, in_terms, out_ready,
        output in_ready, out_valid, out_r
    );
endinterface

// File: rtl/loba_seq_mult_ctrl.sv
// LOBA approximate multiplier controller. Each operand magnitude is split into a
// K-bit high segment at its leading one and a K-bit low segment at the leading
// one of the remainder; up to four partial products (HH, HL, LH, LL) are
// accumulated one per cycle through a single KxK multiplier and shifter.
module loba_seq_mult_ctrl #(
    parameter int K      = 4,
    parameter int NA     = 16,
    parameter int NB     = 16,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    loba_seq_mult_ctrl_if.slave  bus,
    output logic                 busy
);
    localparam int NR = NA + NB;
    localparam int AW = NR + 2;
    localparam int NM = (NA > NB) ? NA : NB;
    localparam int KW = $clog2(2 * NM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [K-1:0]  h;
        logic [KW-1:0] kh;
        logic [K-1:0]  l;
        logic [KW-1:0] kl;
    } seg_t;

    // Position of the most significant set bit; 0 for a zero input.
    function automatic logic [KW-1:0] lead1(input logic [NM-1:0] x);
        logic [KW-1:0] pos;
        pos = '0;
        for (int i = 0; i < NM; i++) begin
            if (x[i]) begin
                pos = KW'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // High segment at the leading one, low segment at the leading one of the remainder.
    function automatic seg_t split_op(input logic [NM-1:0] x);
        seg_t          s;
        logic [KW-1:0] kh;
        logic [KW-1:0] kl;
        logic [NM-1:0] lower;
        kh    = (lead1(x) < KW'(K - 1)) ? KW'(K - 1) : lead1(x);
        lower = x & ((NM'(1) << (kh - KW'(K - 1))) - NM'(1));
        kl    = (lead1(lower) < KW'(K - 1)) ? KW'(K - 1) : lead1(lower);
        s.h   = K'(x >> (kh - KW'(K - 1)));
        s.kh  = kh;
        s.l   = K'(lower >> (kl - KW'(K - 1)));
        s.kl  = kl;
        return s;
    endfunction

    state_t        state_r, state_n;
    logic [NA-1:0] a_mag_r, a_abs_s;
    logic [NB-1:0] b_mag_r, b_abs_s;
    logic [1:0]    terms_r, t_r;
    logic          sign_r;
    seg_t          sa_r, sb_r, sa_s, sb_s;
    logic [AW-1:0] acc_r, acc_n_s, term_s;
    logic [K-1:0]  p_s, q_s;
    logic [KW-1:0] kp_s, kq_s, shift_s;
    logic [2*K-1:0] prod_s;
    logic [NR-1:0] res_s;
    logic [NR-1:0] out_r_r;
    logic          out_valid_r, in_ready_r, busy_r;

    // Operand magnitudes and segment fields of the captured magnitudes.
    always_comb begin
        a_abs_s = ((SIGNED != 0) && bus.in_a[NA-1]) ? (~bus.in_a + NA'(1)) : bus.in_a;
        b_abs_s = ((SIGNED != 0) && bus.in_b[NB-1]) ? (~bus.in_b + NB'(1)) : bus.in_b;
        sa_s    = split_op(NM'(a_mag_r));
        sb_s    = split_op(NM'(b_mag_r));
    end

    // Select the segment pair for the current term and form its shifted product.
    always_comb begin
        p_s  = sa_r.h;
        q_s  = sb_r.h;
        kp_s = sa_r.kh;
        kq_s = sb_r.kh;
        case (t_r)
            2'd0: begin p_s = sa_r.h; kp_s = sa_r.kh; q_s = sb_r.h; kq_s = sb_r.kh; end
            2'd1: begin p_s = sa_r.h; kp_s = sa_r.kh; q_s = sb_r.l; kq_s = sb_r.kl; end
            2'd2: begin p_s = sa_r.l; kp_s = sa_r.kl; q_s = sb_r.h; kq_s = sb_r.kh; end
            2'd3: begin p_s = sa_r.l; kp_s = sa_r.kl; q_s = sb_r.l; kq_s = sb_r.kl; end
            default: begin p_s = sa_r.h; kp_s = sa_r.kh; q_s = sb_r.h; kq_s = sb_r.kh; end
        endcase
        prod_s  = (2*K)'(p_s) * (2*K)'(q_s);
        shift_s = kp_s + kq_s - KW'(2 * (K - 1));
        term_s  = AW'(prod_s) << shift_s;
    end

    // Next state and next accumulator value.
    always_comb begin
        state_n = state_r;
        acc_n_s = acc_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = SPLIT;
                end else begin
                    state_n = IDLE;
                end
            end
            SPLIT: begin
                acc_n_s = '0;
                if ((a_mag_r == '0) || (b_mag_r == '0)) begin
                    state_n = DONE;
                end else begin
                    state_n = MAC;
                end
            end
            MAC: begin
                acc_n_s = acc_r + term_s;
                if (t_r == terms_r) begin
                    state_n = DONE;
                end else begin
                    state_n = MAC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
                acc_n_s = '0;
            end
        endcase
        res_s = NR'(acc_n_s);
        if (sign_r) begin
            res_s = ~res_s + NR'(1);
        end else begin
            res_s = res_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Operand capture, segment fields, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag_r     <= '0;
            b_mag_r     <= '0;
            terms_r     <= 2'd0;
            sign_r      <= 1'b0;
            sa_r        <= '0;
            sb_r        <= '0;
            t_r         <= 2'd0;
            acc_r       <= '0;
            out_r_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            acc_r       <= acc_n_s;
            in_ready_r  <= (state_n == IDLE);
            busy_r      <= (state_n != IDLE);
            out_valid_r <= (state_n == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_mag_r <= a_abs_s;
                        b_mag_r <= b_abs_s;
                        terms_r <= bus.in_terms;
                        sign_r  <= (SIGNED != 0) ? (bus.in_a[NA-1] ^ bus.in_b[NB-1]) : 1'b0;
                    end else begin
                        a_mag_r <= a_mag_r;
                    end
                end
                SPLIT: begin
                    sa_r <= sa_s;
                    sb_r <= sb_s;
                    t_r  <= 2'd0;
                end
                MAC: begin
                    t_r <= t_r + 2'd1;
                end
                DONE: begin
                    t_r <= t_r;
                end
                default: begin
                    t_r <= 2'd0;
                end
            endcase
            if ((state_r != DONE) && (state_n == DONE)) begin
                out_r_r <= res_s;
            end else begin
                out_r_r <= out_r_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_r     = out_r_r;
    assign busy          = busy_r;

endmodule
